result_serializer: RTL
======================

// Module: result_serializer
// PURPOSE
//   Downstream of the matrix Calculator. Captures the 3x3 result (9 x 16-bit elements) on mult_done.
//   Streams it to uart_tx one byte at a time using uart_tx's start/busy handshake.
//   Replaces the ad-hoc result_index/result_byte logic in the top level.
//   Raises done when the last byte has left the transmitter.
// PARAMETERS
//   N_ELEM   9    number of result elements
//   ELEM_W   16   bits per element; must be a multiple of 8
//   BYTE_W   8    UART byte width
// PORTS
//   clk       in   1                  bclk domain, rising edge
//   rst_n     in   1                  asynchronous, active-low reset
//   load      in   1                  1-cycle pulse (mult_done): result is valid
//   result    in   N_ELEM*ELEM_W      packed result; element k = result[k*ELEM_W +: ELEM_W]
//   ready     out  1                  high only in IDLE; load is accepted only when ready=1
//   tx_data   out  BYTE_W             byte presented to uart_tx
//   tx_start  out  1                  1-cycle request to uart_tx
//   tx_busy   in   1                  uart_tx busy
//   done      out  1                  1-cycle pulse after the final byte has completed
// BEHAVIOUR
//   Reset values (async, rst_n=0): state=IDLE, ready=1, tx_start=0, tx_data=0, done=0, byte_cnt=0, capture reg=0.
//   States: IDLE -> ISSUE -> WAIT_ACK -> WAIT_FREE -> (ISSUE | DONE) -> IDLE.
//   IDLE:      on load=1, copy result into the capture register and set byte_cnt=0, then go to ISSUE.
//   ISSUE:     wait for tx_busy=0. In that cycle drive tx_data=byte(byte_cnt) and tx_start=1 for exactly one cycle,
//              then go to WAIT_ACK.
//   WAIT_ACK:  wait for tx_busy=1, then go to WAIT_FREE. tx_start is 0. tx_data holds its value.
//   WAIT_FREE: wait for tx_busy=0.
//              If byte_cnt = TOTAL-1, go to DONE. Otherwise increment byte_cnt and go to ISSUE.
//   DONE:      done=1 for one cycle, then go to IDLE.
//   TOTAL = N_ELEM*ELEM_W/BYTE_W (18 at defaults). byte_cnt is $clog2(TOTAL+1) bits wide.
//   Byte order: element 0 first. Within an element the MSB byte goes first.
//     byte(i) = capture[(i/2)*16 + 8 +: 8] for even i, capture[(i/2)*16 +: 8] for odd i.
//   Latency: tx_start rises 2 cycles after load when tx_busy=0 (capture cycle, then ISSUE). Minimum 3 cycles/byte plus UART time.
//   Boundary conditions:
//     load while not in IDLE: ignored. The capture register is unchanged and the stream continues.
//     load with tx_busy=1: capture anyway; ISSUE stalls until tx_busy=0.
//     tx_busy=1 in the same cycle as tx_start: treated as the acknowledge. WAIT_ACK exits on the next cycle.
//     byte_cnt never wraps during a stream. It is reset to 0 only on load.
//     rst_n low mid-stream: immediate abort. tx_start=0 asynchronously, no done pulse; the partial byte is uart_tx's concern.
//     The capture register isolates the output from the Calculator changing result mid-stream.
// CONFIGURATION
//   RESULT_CKSUM_EN defined:
//     After byte TOTAL-1, one extra byte is sent: the XOR of all TOTAL data bytes.
//     The checksum is accumulated at each tx_start and cleared on load.
//     done fires after the checksum byte. TOTAL_TX = TOTAL+1 (19).
//   RESULT_CKSUM_EN undefined: exactly TOTAL bytes are sent and no accumulator is built.
// STRUCTURE
//   Shared package matmul_pkg holds:
//     N_ELEM, ELEM_W, BYTE_W, TOTAL;
//     the state enum ser_state_t {IDLE, ISSUE, WAIT_ACK, WAIT_FREE, DONE};
//     the 3-bit state encodings shared with control_unit's SEND_RESULT.
//   No sub-module. Byte selection is an indexed part-select inside the block.
//   A generic tx_handshake sub-module is not warranted for a single client.
// TESTING
//   1. Reset, then load with element k = 16'h0100*k + k (elements 0..8), tx_busy model = 10 cycles busy after start.
//      -> 18 bytes: 00,00,01,01,02,02,...,08,08, then one done pulse.
//   2. Result = {9{16'hA55A}}, load while tx_busy=1 for 20 cycles.
//      -> no tx_start before tx_busy falls; first byte A5, second 5A.
//   3. Second load pulse at byte 5 with a different result.
//      -> ignored; remaining bytes come from the first capture; ready=0 throughout.
//   4. rst_n low at byte 7.
//      -> tx_start=0 immediately, ready=1, no done.
//      Then a new load -> stream restarts from byte 0.
//   5. With RESULT_CKSUM_EN and result elements 16'h0001..16'h0009.
//      -> 19th byte = XOR of the 18 data bytes = 8'h01; done only after the 19th byte.
//   6. uart_tx model that asserts busy in the same cycle as tx_start.
//      -> exactly one tx_start per byte, with no duplicate or skipped bytes.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared constants and state encoding for the matrix result path.
// RESULT_CKSUM_EN adds a trailing XOR checksum byte to the result stream.
package matmul_pkg;
   localparam int N_ELEM = 9;
   localparam int ELEM_W = 16;
   localparam int BYTE_W = 8;
   localparam int TOTAL  = N_ELEM * ELEM_W / BYTE_W;
   localparam int BPE    = ELEM_W / BYTE_W;
   localparam int CNT_W  = $clog2(TOTAL + 1);
`ifdef RESULT_CKSUM_EN
   localparam int TOTAL_TX = TOTAL + 1;
`else
   localparam int TOTAL_TX = TOTAL;
`endif

   // Encodings are shared with control_unit's SEND_RESULT sub-states.
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ISSUE     = 3'd1,
      WAIT_ACK  = 3'd2,
      WAIT_FREE = 3'd3,
      DONE      = 3'd4
   } ser_state_t;
endpackage

// File: rtl/result_serializer.sv
// Captures the 3x3 result on load and streams it byte-by-byte to uart_tx.
// Optional RESULT_CKSUM_EN appends an XOR checksum byte before done.
module result_serializer
   import matmul_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       load,
   input  logic [N_ELEM*ELEM_W-1:0]   result,
   output logic                       ready,
   output logic [BYTE_W-1:0]          tx_data,
   output logic                       tx_start,
   input  logic                       tx_busy,
   output logic                       done
);
   ser_state_t               state, state_nx;
   logic [N_ELEM*ELEM_W-1:0] capture;
   logic [CNT_W-1:0]         byte_cnt;
   logic [BYTE_W-1:0]        data_q, cur_byte;
   logic                     last;
   int unsigned              byte_off;
`ifdef RESULT_CKSUM_EN
   logic [BYTE_W-1:0]        cksum;
`endif

   assign last = (byte_cnt == CNT_W'(TOTAL_TX - 1));

   // Element 0 first; within an element the MSB byte leaves first.
   always_comb begin
      byte_off = 0;
      if (int'(byte_cnt) < TOTAL)
         byte_off = (int'(byte_cnt) / BPE) * ELEM_W + (BPE - 1 - int'(byte_cnt) % BPE) * BYTE_W;
      cur_byte = capture[byte_off +: BYTE_W];
`ifdef RESULT_CKSUM_EN
      if (int'(byte_cnt) == TOTAL) cur_byte = cksum;
`endif
   end

   always_comb begin
      state_nx = state;
      tx_start = 1'b0;
      case (state)
         IDLE:      if (load) state_nx = ISSUE;
         ISSUE:     if (!tx_busy) begin
                       tx_start = 1'b1;
                       state_nx = WAIT_ACK;
                    end
         WAIT_ACK:  if (tx_busy) state_nx = WAIT_FREE;
         WAIT_FREE: if (!tx_busy) state_nx = last ? DONE : ISSUE;
         DONE:      state_nx = IDLE;
         default:   state_nx = IDLE;
      endcase
   end

   assign ready   = (state == IDLE);
   assign done    = (state == DONE);
   assign tx_data = (state == ISSUE) ? cur_byte : data_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         capture  <= '0;
         byte_cnt <= '0;
         data_q   <= '0;
      end else begin
         if (state == IDLE && load) begin
            capture  <= result;
            byte_cnt <= '0;
         end
         if (tx_start) data_q <= cur_byte;
         if (state == WAIT_FREE && !tx_busy && !last) byte_cnt <= byte_cnt + 1'b1;
      end
   end

`ifdef RESULT_CKSUM_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                              cksum <= '0;
      else if (state == IDLE && load)          cksum <= '0;
      else if (tx_start && int'(byte_cnt) < TOTAL) cksum <= cksum ^ cur_byte;
   end
`endif
endmodule
